// File: rtl/pcileech_com_txarb_pkg.sv
// rtl/pcileech_com_txarb_pkg.sv - shared constants and types for the COM TX arbiter
//
// Purpose: requester count, header magic, arbiter state type and the header
//          word builder shared by the COM TX arbiter files.
// Ports:   none (package).
package pcileech_com_txarb_pkg;

  localparam int          COM_NREQ      = 4;
  localparam logic [15:0] COM_HDR_MAGIC = 16'hA5C0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BURST
  } txarb_state_t;

  // Header word: magic, continuation bit, zero pad, requester index.
  function automatic logic [31:0] com_hdr(input logic cont, input logic [1:0] id);
    return {COM_HDR_MAGIC, cont, 13'b0, id};
  endfunction

endpackage

// File: rtl/pcileech_rr_pick4.sv
// rtl/pcileech_rr_pick4.sv - combinational 4-way round-robin selector
//
// Purpose: picks the first requester with req set, searching from last+1
//          upward modulo 4; the last granted requester has lowest priority.
// Ports:   req   - request vector
//          last  - index of the previous grant
//          pick  - selected requester (only meaningful when found=1)
//          found - at least one request present
module pcileech_rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       found
);

  // Scan from lowest to highest priority so the highest-priority hit is
  // the one that sticks (offset 4 wraps to 'last' itself).
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[last + 2'(k)]) begin
        pick  = last + 2'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcileech_com_txarb.sv
// rtl/pcileech_com_txarb.sv - round-robin TX arbiter feeding the COM TX FIFO
//
// Purpose: grants one of NREQ requesters at a time, emits a header word and
//          then up to MAX_BURST payload words of that requester's packet.
//          Packets cut at MAX_BURST resume later with the header cont bit set.
// Ports:   clk, rst             - clock, synchronous active-high reset
//          req_valid/data/last  - per-requester word stream
//          req_ready            - per-requester accept (combinational)
//          out_data, out_wr_en  - registered word toward the COM TX FIFO
//          out_ready            - downstream can take a word
//          grant_id             - current or last granted requester
//          busy                 - arbiter not idle
module pcileech_com_txarb
  import pcileech_com_txarb_pkg::*;
#(
  parameter int NREQ      = COM_NREQ,
  parameter int MAX_BURST = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0][31:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          out_data,
  output logic                 out_wr_en,
  input  logic                 out_ready,
  output logic [1:0]           grant_id,
  output logic                 busy
);

  localparam logic [15:0] MAX_W      = 16'(MAX_BURST);
  localparam logic [15:0] BURST_LAST = 16'(MAX_BURST - 1);

  txarb_state_t    state, state_nx;
  logic [1:0]      grant_nx;
  logic [1:0]      pick;
  logic            pick_found;
  logic [15:0]     wcnt, wcnt_nx;
  logic [NREQ-1:0] cont, cont_nx;
  logic [31:0]     data_nx;
  logic            wr_nx;
  logic            accept;

  pcileech_rr_pick4 u_pick (
    .req   (req_valid),
    .last  (grant_id),
    .pick  (pick),
    .found (pick_found)
  );

  always_comb begin
    req_ready = '0;
    if (state == ST_BURST && out_ready && wcnt < MAX_W)
      req_ready[grant_id] = 1'b1;
  end

  assign accept = req_valid[grant_id] & req_ready[grant_id];
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    wcnt_nx  = wcnt;
    cont_nx  = cont;
    data_nx  = out_data;
    wr_nx    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nx = pick;
          wcnt_nx  = '0;
          state_nx = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_ready) begin
          data_nx  = com_hdr(cont[grant_id], grant_id);
          wr_nx    = 1'b1;
          state_nx = ST_BURST;
        end
      end
      ST_BURST: begin
        // A missing req_valid simply holds the grant; nothing else may cut in.
        if (accept) begin
          data_nx = req_data[grant_id];
          wr_nx   = 1'b1;
          wcnt_nx = wcnt + 16'd1;
          if (req_last[grant_id]) begin
            cont_nx[grant_id] = 1'b0;
            state_nx          = ST_IDLE;
          end else if (wcnt == BURST_LAST) begin
            // Burst budget spent mid-packet: remember to flag the resume.
            cont_nx[grant_id] = 1'b1;
            state_nx          = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant_id  <= 2'd3;
      wcnt      <= '0;
      cont      <= '0;
      out_data  <= '0;
      out_wr_en <= 1'b0;
    end else begin
      state     <= state_nx;
      grant_id  <= grant_nx;
      wcnt      <= wcnt_nx;
      cont      <= cont_nx;
      out_data  <= data_nx;
      out_wr_en <= wr_nx;
    end
  end

endmodule

// File: tb/tb_pcileech_com_txarb.sv
// tb/tb_pcileech_com_txarb.sv - self-checking bench for pcileech_com_txarb
module tb_pcileech_com_txarb;

  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_valid;
  logic [3:0][31:0] req_data;
  logic [3:0]      req_last;
  logic [3:0]      req_ready;
  logic [31:0]     out_data;
  logic            out_wr_en;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pcileech_com_txarb #(.NREQ(4), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_wr_en (out_wr_en),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // requester stimulus queues
  logic [31:0] drv_data[4][$];
  bit          drv_last[4][$];
  bit          rand_ready = 1'b0;
  bit          rand_gap   = 1'b0;

  // packet-level reference model
  logic [31:0] mq_data[4][$];
  int          mq_plen[4][$];
  int          m_off[4];
  bit          m_cont[4];
  int          m_last;
  logic [31:0] exp_q[$];

  // observed output
  logic [31:0] mon_q[$];
  int          mon_t[$];
  int          viol = 0;
  bit          prev_rdy = 1'b1;

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    forever begin
      logic [3:0] acc;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && drv_data[i].size() > 0) begin
          void'(drv_data[i].pop_front());
          void'(drv_last[i].pop_front());
        end
        if (drv_data[i].size() > 0) begin
          req_data[i]  = drv_data[i][0];
          req_last[i]  = drv_last[i][0];
          req_valid[i] = !(rand_gap && busy && grant_id == 2'(i) && $urandom_range(0, 2) == 0);
        end else begin
          req_valid[i] = 1'b0;
          req_data[i]  = '0;
          req_last[i]  = 1'b0;
        end
      end
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_wr_en === 1'b1) begin
        mon_q.push_back(out_data);
        mon_t.push_back(cyc);
        if (!prev_rdy) viol++;
      end
      if (req_ready != 4'b0 && (!out_ready || req_ready != (4'b1 << grant_id))) viol++;
      prev_rdy = out_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic add_pkt(input int r, input int len, input logic [31:0] base);
    for (int k = 0; k < len; k++) begin
      drv_data[r].push_back(base + 32'(k));
      drv_last[r].push_back(k == len - 1);
      mq_data[r].push_back(base + 32'(k));
    end
    mq_plen[r].push_back(len);
  endtask

  // Packet-level arbitration: every pending requester is assumed present at
  // each arbitration point; grants rotate from the last winner, each grant
  // carries at most MB words of the current packet.
  function automatic void model_run();
    forever begin
      int r;
      int rem;
      int n;
      r = -1;
      for (int k = 1; k <= 4; k++) begin
        if (r < 0 && mq_plen[(m_last + k) % 4].size() > 0) r = (m_last + k) % 4;
      end
      if (r < 0) break;
      m_last = r;
      exp_q.push_back(32'hA5C0_0000 | (m_cont[r] ? 32'h8000 : 32'h0) | 32'(r));
      rem = mq_plen[r][0] - m_off[r];
      n   = (rem > MB) ? MB : rem;
      for (int k = 0; k < n; k++) exp_q.push_back(mq_data[r].pop_front());
      if (rem > MB) begin
        m_off[r]  = m_off[r] + MB;
        m_cont[r] = 1'b1;
      end else begin
        m_off[r]  = 0;
        m_cont[r] = 1'b0;
        void'(mq_plen[r].pop_front());
      end
    end
  endfunction

  function automatic void model_reset();
    m_last = 3;
    for (int r = 0; r < 4; r++) begin
      m_off[r]  = 0;
      m_cont[r] = 1'b0;
      mq_data[r].delete();
      mq_plen[r].delete();
    end
  endfunction

  function automatic logic [31:0] mon_at(input int i);
    return (i < mon_q.size()) ? mon_q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic wait_idle(input int budget, output bit to);
    int idle;
    bit empty;
    idle = 0;
    to   = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      empty = 1'b1;
      for (int r = 0; r < 4; r++) if (drv_data[r].size() != 0) empty = 1'b0;
      if (empty && !busy && !out_wr_en) idle++;
      else idle = 0;
      if (idle >= 3) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_test();
    mon_q.delete();
    mon_t.delete();
    exp_q.delete();
    viol = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (out_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", out_wr_en); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL reset_grant got=%0d want=3", grant_id); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [31:0] want[4];
    bit to;
    start_test();
    want = '{32'hA5C0_0000, 32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
    add_pkt(0, 3, 32'h1000_0000);
    wait_idle(200, to);
    model_run();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != 4) begin bad++; $display("FAIL single_len got=%0d want=4", mon_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mon_at(i) !== want[i]) begin bad++; $display("FAIL single_word%0d got=%h want=%h", i, mon_at(i), want[i]); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant got=%0d want=0", grant_id); end
  endtask

  task automatic test_round_robin();
    logic [31:0] want[10];
    bit to;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    start_test();
    want = '{32'hA5C0_0000, 32'h2000_0000, 32'hA5C0_0001, 32'h2100_0000, 32'hA5C0_0002,
             32'h2200_0000, 32'hA5C0_0003, 32'h2300_0000, 32'hA5C0_0000, 32'h2000_0100};
    add_pkt(0, 1, 32'h2000_0000);
    add_pkt(0, 1, 32'h2000_0100);
    add_pkt(1, 1, 32'h2100_0000);
    add_pkt(2, 1, 32'h2200_0000);
    add_pkt(3, 1, 32'h2300_0000);
    wait_idle(300, to);
    model_run();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL rr_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != 10) begin bad++; $display("FAIL rr_len got=%0d want=10", mon_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mon_at(i) !== want[i]) begin bad++; $display("FAIL rr_word%0d got=%h want=%h", i, mon_at(i), want[i]); end
    end
    total++; if (viol != 0) begin bad++; $display("FAIL rr_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_preempt();
    logic [31:0] want[10];
    bit to;
    start_test();
    want = '{32'hA5C0_0002, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003,
             32'hA5C0_8002, 32'h3000_0004, 32'h3000_0005, 32'hA5C0_0002, 32'h3000_0100};
    add_pkt(2, 6, 32'h3000_0000);
    wait_idle(300, to);
    add_pkt(2, 1, 32'h3000_0100);
    wait_idle(300, to);
    model_run();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL preempt_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != 10) begin bad++; $display("FAIL preempt_len got=%0d want=10", mon_q.size()); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (mon_at(i) !== want[i]) begin bad++; $display("FAIL preempt_word%0d got=%h want=%h", i, mon_at(i), want[i]); end
    end
    if (mon_t.size() >= 6) begin
      total++;
      if (mon_t[5] - mon_t[4] != 2) begin bad++; $display("FAIL preempt_gap got=%0d want=2", mon_t[5] - mon_t[4]); end
    end
  endtask

  task automatic test_back_to_back();
    int want_dt[5];
    bit to;
    start_test();
    want_dt = '{1, 1, 2, 1, 1};
    add_pkt(1, 2, 32'h5000_0000);
    add_pkt(1, 2, 32'h5000_0100);
    wait_idle(300, to);
    model_run();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL b2b_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != 6) begin bad++; $display("FAIL b2b_len got=%0d want=6", mon_q.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (mon_at(i) !== exp_q[i]) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, mon_at(i), exp_q[i]); end
    end
    for (int i = 0; i < 5 && i + 1 < mon_t.size(); i++) begin
      total++;
      if (mon_t[i+1] - mon_t[i] != want_dt[i]) begin
        bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, mon_t[i+1] - mon_t[i], want_dt[i]);
      end
    end
  endtask

  task automatic test_ready_toggle();
    bit to;
    int miss;
    start_test();
    rand_ready = 1'b1;
    add_pkt(2, 100, $urandom);
    wait_idle(3000, to);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    model_run();
    miss = 0;
    for (int i = 0; i < exp_q.size(); i++) if (mon_at(i) !== exp_q[i]) miss++;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL toggle_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != 125) begin bad++; $display("FAIL toggle_len got=%0d want=125", mon_q.size()); end
    total++; if (miss != 0) begin bad++; $display("FAIL toggle_content got=%0d_bad_words want=0", miss); end
    total++; if (viol != 0) begin bad++; $display("FAIL toggle_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_random_mix();
    bit to;
    int miss;
    start_test();
    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 4; r++) add_pkt(r, $urandom_range(1, 7), $urandom);
    wait_idle(5000, to);
    rand_ready = 1'b0;
    rand_gap   = 1'b0;
    out_ready  = 1'b1;
    model_run();
    miss = 0;
    for (int i = 0; i < exp_q.size(); i++) if (mon_at(i) !== exp_q[i]) miss++;
    total++; if (to !== 1'b0) begin bad++; $display("FAIL mix_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != exp_q.size()) begin bad++; $display("FAIL mix_len got=%0d want=%0d", mon_q.size(), exp_q.size()); end
    total++; if (miss != 0) begin bad++; $display("FAIL mix_content got=%0d_bad_words want=0", miss); end
    total++; if (viol != 0) begin bad++; $display("FAIL mix_protocol got=%0d want=0", viol); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] want[5];
    bit to;
    int n;
    start_test();
    add_pkt(3, 10, 32'h4000_0000);
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (mon_q.size() >= 7) begin
        to = 1'b0;
        break;
      end
    end
    total++; if (to !== 1'b0) begin bad++; $display("FAIL abort_timeout got=%b want=0", to); end
    total++; if (mon_at(5) !== 32'hA5C0_8003) begin bad++; $display("FAIL abort_contHdr got=%h want=a5c08003", mon_at(5)); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    for (int r = 0; r < 4; r++) begin
      drv_data[r].delete();
      drv_last[r].delete();
    end
    req_valid = '0;
    rst = 1'b0;
    model_reset();
    total++; if (out_wr_en !== 1'b0) begin bad++; $display("FAIL abort_wr_en got=%b want=0", out_wr_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    @(negedge clk);
    n = mon_q.size();
    repeat (10) @(negedge clk);
    total++; if (mon_q.size() != n) begin bad++; $display("FAIL abort_quiet got=%0d want=%0d", mon_q.size(), n); end

    start_test();
    want = '{32'hA5C0_0000, 32'h4200_0000, 32'hA5C0_0003, 32'h4100_0000, 32'h4100_0001};
    add_pkt(3, 2, 32'h4100_0000);
    add_pkt(0, 1, 32'h4200_0000);
    wait_idle(300, to);
    model_run();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL after_abort_timeout got=%b want=0", to); end
    total++; if (mon_q.size() != 5) begin bad++; $display("FAIL after_abort_len got=%0d want=5", mon_q.size()); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mon_at(i) !== want[i]) begin bad++; $display("FAIL after_abort_word%0d got=%h want=%h", i, mon_at(i), want[i]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_back_to_back();
    test_ready_toggle();
    test_random_mix();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
